conv_window_gen: RTL and testbench

- Streaming 5x5 sliding-window generator. Sits directly upstream of the multiply stage that feeds adder_tree.
- Accepts one raster-order Q8.8 pixel per valid cycle and keeps 4 line buffers plus a 5x5 register window.
- Emits all 25 taps of each "valid" (unpadded) convolution window, together with a qualifying strobe.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 30 +++
 rtl/conv_window_gen.sv | 145 ++++++++++++++
 tb/tb_conv_window_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, pixel type and tap indexing for the 5x5
// convolution front end (conv_window_gen and conv_line_buffer).
//   KERNEL_SIZE : window edge length (fixed 5)
//   NUM_TAPS    : taps per window (25)
//   FRAC_BITS   : fractional bits of the Q8.8 pixel format
//   pixel_t     : signed Q8.8 pixel at the default 16-bit width
//   tap_idx     : flat tap index of window element (r, c); r=0 oldest row, c=0 oldest column
package conv_pkg;

    localparam int unsigned KERNEL_SIZE = 5;
    localparam int unsigned NUM_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned FRAC_BITS   = 8;
    localparam int unsigned PIXEL_WIDTH = 16;

    typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
        return r * KERNEL_SIZE + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of pixel storage, DEPTH entries deep.
//   clk     : rising-edge clock
//   wr_en   : write wr_data into entry addr at the clock edge
//   addr    : shared read/write address (column index)
//   wr_data : pixel to store
//   rd_data : combinational read of entry addr (returns the pre-write value)
// Contents are deliberately not reset.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 5x5 sliding-window generator for raster-order
// Q8.8 pixels. Four chained line buffers supply the four previous rows of the
// current column; a 5x5 register window shifts left on every accepted pixel.
// Only fully-populated (unpadded) windows are emitted.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : pixel strobe (no backpressure, gaps allowed)
//   in_data    : signed pixel
//   out_valid  : one-cycle strobe per emitted window (1 clk after the accept)
//   out_window : 25 taps, tap k = r*5+c at [k*DATA_WIDTH +: DATA_WIDTH]
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// Optional (macro CONV_WINDOW_COORD_EN):
//   out_row, out_col : output-feature-map coordinate of the emitted window
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL     = 5,
    localparam int CW        = $clog2(IMG_WIDTH),
    localparam int RW        = $clog2(IMG_HEIGHT),
    localparam int OUT_ROW_W = (IMG_HEIGHT > 5) ? $clog2(IMG_HEIGHT - 4) : 1,
    localparam int OUT_COL_W = (IMG_WIDTH > 5) ? $clog2(IMG_WIDTH - 4) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] out_window,
    output logic                           frame_done
`ifdef CONV_WINDOW_COORD_EN
    ,
    output logic [OUT_ROW_W-1:0]           out_row,
    output logic [OUT_COL_W-1:0]           out_col
`endif
);

    if (KERNEL != KERNEL_SIZE) begin : g_bad_kernel
        $error("conv_window_gen: KERNEL must be 5");
    end
    if (IMG_WIDTH < 5 || IMG_HEIGHT < 5) begin : g_bad_size
        $error("conv_window_gen: image must be at least 5x5");
    end

    localparam int LB_COUNT = KERNEL_SIZE - 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  last_col;
    logic                  last_row;
    logic                  qualify;

    logic [DATA_WIDTH-1:0] lb_wr [LB_COUNT];
    logic [DATA_WIDTH-1:0] lb_rd [LB_COUNT];
    logic [DATA_WIDTH-1:0] new_col [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] win_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] win_d [NUM_TAPS];
    logic [NUM_TAPS*DATA_WIDTH-1:0] win_flat;

    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));
    assign qualify  = in_valid && (row >= RW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1));

    // lb0 takes the incoming pixel; each deeper buffer takes the pre-write
    // value of the one before it, so one row ripples down per visit to a column.
    assign lb_wr[0] = in_data;
    for (genvar i = 0; i < LB_COUNT; i++) begin : g_lb
        if (i > 0) begin : g_chain
            assign lb_wr[i] = lb_rd[i-1];
        end
        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_lb (
            .clk     (clk),
            .wr_en   (in_valid),
            .addr    (col),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end

    // Window row 0 is the oldest image row (lb3), row 4 is the live pixel.
    always_comb begin
        for (int unsigned r = 0; r < LB_COUNT; r++) begin
            new_col[r] = lb_rd[LB_COUNT-1-r];
        end
        new_col[KERNEL_SIZE-1] = in_data;
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
            for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
                if (c < KERNEL_SIZE - 1) begin
                    win_d[tap_idx(r, c)] = win_q[tap_idx(r, c + 1)];
                end else begin
                    win_d[tap_idx(r, c)] = new_col[r];
                end
            end
        end
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            win_flat[k*DATA_WIDTH +: DATA_WIDTH] = win_d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
            win_q      <= '{default: '0};
        end else begin
            out_valid  <= qualify;
            frame_done <= in_valid && last_col && last_row;
            if (in_valid) begin
                win_q <= win_d;
                col   <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    row <= last_row ? '0 : row + 1'b1;
                end
            end
            if (qualify) begin
                out_window <= win_flat;
            end
        end
    end

`ifdef CONV_WINDOW_COORD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
        end else if (qualify) begin
            out_row <= OUT_ROW_W'(row - RW'(KERNEL_SIZE - 1));
            out_col <= OUT_COL_W'(col - CW'(KERNEL_SIZE - 1));
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: self-checking bench for conv_window_gen on an 8x8 image.
// A reference model stores the current frame as a 2-D image and builds each
// expected window directly from image coordinates.
// Honours CONV_WINDOW_COORD_EN to check the optional coordinate outputs.
module tb_conv_window_gen;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = 25 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [WB-1:0] out_window;
    logic          frame_done;
`ifdef CONV_WINDOW_COORD_EN
    logic [1:0]    out_row;
    logic [1:0]    out_col;
`endif

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .KERNEL     (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_window (out_window),
        .frame_done (frame_done)
`ifdef CONV_WINDOW_COORD_EN
        ,
        .out_row    (out_row),
        .out_col    (out_col)
`endif
    );

    always #5 clk = ~clk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    // reference model state
    logic [DW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    logic [WB-1:0] exp_hold = '0;
    logic [1:0]    exp_row = '0;
    logic [1:0]    exp_col = '0;

    // per-frame observations
    int            win_seen;
    int            done_seen;
    logic [WB-1:0] first_win;
    logic [WB-1:0] last_win;
    bit            last_had_done;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int kind, input int r, input int c);
        logic [DW-1:0] v;
        case (kind)
            0:       v = DW'(r * 8 + c);
            1:       v = DW'(r * 8 + c + 100);
            2:       v = DW'(-(r * 8 + c));
            default: v = DW'($urandom);
        endcase
        return v;
    endfunction

    // One clock with the given inputs; outputs sampled 1 ns after the edge.
    task automatic step(input bit v, input logic [DW-1:0] d);
        bit exp_v = 1'b0;
        bit exp_d = 1'b0;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        if (v) begin
            img[mr][mc] = d;
            if (mr >= 4 && mc >= 4) begin
                exp_v = 1'b1;
                for (int dr = 0; dr < 5; dr++)
                    for (int dc = 0; dc < 5; dc++)
                        exp_hold[(dr*5+dc)*DW +: DW] = img[mr-4+dr][mc-4+dc];
                exp_row = 2'(mr - 4);
                exp_col = 2'(mc - 4);
            end
            exp_d = (mr == H - 1) && (mc == W - 1);
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        check("out_valid", WB'(out_valid), WB'(exp_v));
        check("frame_done", WB'(frame_done), WB'(exp_d));
        check("out_window", out_window, exp_hold);
`ifdef CONV_WINDOW_COORD_EN
        check("out_row", WB'(out_row), WB'(exp_row));
        check("out_col", WB'(out_col), WB'(exp_col));
`endif
        if (out_valid) begin
            if (win_seen == 0) first_win = out_window;
            last_win = out_window;
            last_had_done = frame_done;
            win_seen++;
        end
        if (frame_done) done_seen++;
    endtask

    // Feeds npix pixels (from the model's current position) with idle gaps
    // at roughly (100-duty)% probability.
    task automatic feed(input int kind, input int npix, input int duty);
        for (int i = 0; i < npix; i++) begin
            while (int'($urandom_range(99)) >= duty) step(1'b0, DW'($urandom));
            step(1'b1, pix(kind, mr, mc));
        end
    endtask

    task automatic new_frame_stats();
        win_seen = 0;
        done_seen = 0;
        first_win = '0;
        last_win = '0;
        last_had_done = 1'b0;
    endtask

    task automatic check_ramp_frame(input string tag, input int base);
        check({tag, "_count"}, WB'(win_seen), WB'(16));
        check({tag, "_done"}, WB'(done_seen), WB'(1));
        check({tag, "_tap0"}, WB'(first_win[0*DW +: DW]), WB'(base + 0));
        check({tag, "_tap4"}, WB'(first_win[4*DW +: DW]), WB'(base + 4));
        check({tag, "_tap12"}, WB'(first_win[12*DW +: DW]), WB'(base + 18));
        check({tag, "_tap20"}, WB'(first_win[20*DW +: DW]), WB'(base + 32));
        check({tag, "_tap24"}, WB'(first_win[24*DW +: DW]), WB'(base + 36));
        check({tag, "_last_tap0"}, WB'(last_win[0*DW +: DW]), WB'(base + 27));
        check({tag, "_last_tap24"}, WB'(last_win[24*DW +: DW]), WB'(base + 63));
        check({tag, "_last_done"}, WB'(last_had_done), WB'(1));
    endtask

    initial begin
        // reset state
        #3;
        check("reset_valid", WB'(out_valid), WB'(0));
        check("reset_done", WB'(frame_done), WB'(0));
        check("reset_window", out_window, '0);
        in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // continuous ramp
        new_frame_stats();
        feed(0, 64, 100);
        check_ramp_frame("ramp", 0);

        // ramp with ~50% gaps
        new_frame_stats();
        feed(0, 64, 50);
        check_ramp_frame("gap_ramp", 0);
        step(1'b0, '0);
        step(1'b0, '0);

        // back-to-back frames: ramp then ramp+100
        new_frame_stats();
        feed(0, 64, 100);
        check_ramp_frame("b2b_a", 0);
        new_frame_stats();
        feed(1, 64, 100);
        check_ramp_frame("b2b_b", 100);

        // mid-frame reset while out_valid is high
        feed(0, 37, 100);
        check("pre_reset_valid", WB'(out_valid), WB'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", WB'(out_valid), WB'(0));
        check("async_done", WB'(frame_done), WB'(0));
        check("async_window", out_window, '0);
        mr = 0;
        mc = 0;
        exp_hold = '0;
        exp_row = '0;
        exp_col = '0;
        in_valid = 1'b1;
        in_data = 16'h1234;
        @(posedge clk);
        #1;
        check("in_reset_valid", WB'(out_valid), WB'(0));
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        new_frame_stats();
        feed(0, 64, 100);
        check_ramp_frame("post_reset", 0);

        // negative ramp with gaps
        new_frame_stats();
        feed(2, 64, 60);
        check("neg_count", WB'(win_seen), WB'(16));
        check("neg_tap24", WB'(first_win[24*DW +: DW]), WB'(16'hFFDC));
        check("neg_last_tap24", WB'(last_win[24*DW +: DW]), WB'(16'hFFC1));

        // random data, random gaps
        for (int f = 0; f < 2; f++) begin
            new_frame_stats();
            feed(3, 64, 40 + f * 30);
            check("rand_count", WB'(win_seen), WB'(16));
            check("rand_done", WB'(done_seen), WB'(1));
        end
        for (int i = 0; i < 4; i++) step(1'b0, DW'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
